midi_rx: RTL and testbench

Serial MIDI front end for the synth. Receives the 31250-baud MIDI stream on a single input pin, deserialises bytes (8N1), applies MIDI framing rules (running status, real-time interleave, SysEx drop), and presents each complete 3-byte channel message as a 24-bit event word. It sits directly upstream of the MIDI voice/envelope controller, which consumes `midi_event_out` and detects new events by change in value.

---
 rtl/midi_rx.sv | 171 +++++++++++++++++
 tb/tb_midi_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/midi_rx.sv
// MIDI serial front end: 8N1 deserialiser plus running-status parser emitting 3-byte channel messages.
// Optional MIDI_VEL0_NOTE_OFF_EN rewrites note-on with velocity 0 into note-off.
module midi_rx #(
    parameter int BAUD_DIV = 3146
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rx_in,
    output logic [23:0] midi_event_out,
    output logic        event_valid_out,
    output logic        framing_err_out
);

    localparam int TW = $clog2(BAUD_DIV);
    localparam logic [TW-1:0] HALF_M1 = TW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    state_t          state_q, state_d;
    logic            rx_meta_q, rx_meta_d;
    logic            rx_sync_q, rx_sync_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            byte_valid_q, byte_valid_d;
    logic            framing_err_q, framing_err_d;
    logic [7:0]      run_status_q, run_status_d;
    logic            data_cnt_q, data_cnt_d;
    logic [7:0]      data1_q, data1_d;
    logic [23:0]     event_q, event_d;
    logic            event_valid_q, event_valid_d;

    function automatic logic [23:0] shape_event(input logic [7:0] st,
                                                input logic [7:0] d1,
                                                input logic [7:0] d2);
`ifdef MIDI_VEL0_NOTE_OFF_EN
        if (st[7:4] == 4'h9 && d2 == 8'h00) begin
            return {4'h8, st[3:0], d1, d2};
        end
        return {st, d1, d2};
`else
        return {st, d1, d2};
`endif
    endfunction

    // Receiver: IDLE only ever sees a high line on entry, so a low level there is a falling edge.
    always_comb begin
        rx_meta_d     = rx_in;
        rx_sync_d     = rx_meta_q;
        state_d       = state_q;
        timer_d       = timer_q + 1'b1;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        byte_valid_d  = 1'b0;
        framing_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = ST_START;
                    timer_d = '0;
                end
            end
            ST_START: begin
                if (timer_q == HALF_M1) begin
                    timer_d   = '0;
                    bit_cnt_d = 3'd0;
                    state_d   = rx_sync_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (timer_q == FULL_M1) begin
                    timer_d   = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        framing_err_d = 1'b1;
                        state_d       = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_sync_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_WAIT_HIGH;
        endcase
    end

    // Parser: shift_q holds the byte untouched until the next frame's first data sample.
    always_comb begin
        run_status_d  = run_status_q;
        data_cnt_d    = data_cnt_q;
        data1_d       = data1_q;
        event_d       = event_q;
        event_valid_d = 1'b0;
        if (byte_valid_q) begin
            if (shift_q >= 8'hF8) begin
                run_status_d = run_status_q;
            end else if (shift_q >= 8'hF0) begin
                run_status_d = 8'h00;
                data_cnt_d   = 1'b0;
            end else if (shift_q[7]) begin
                run_status_d = shift_q;
                data_cnt_d   = 1'b0;
            end else if (run_status_q[7]) begin
                if (run_status_q[7:4] == 4'hC || run_status_q[7:4] == 4'hD) begin
                    data_cnt_d = 1'b0;
                end else if (!data_cnt_q) begin
                    data1_d    = shift_q;
                    data_cnt_d = 1'b1;
                end else begin
                    event_d       = shape_event(run_status_q, data1_q, shift_q);
                    event_valid_d = 1'b1;
                    data_cnt_d    = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        timer_q   <= timer_d;
        bit_cnt_q <= bit_cnt_d;
        shift_q   <= shift_d;
        data1_q   <= data1_d;
        if (!rst_in) begin
            rx_meta_q     <= 1'b0;
            rx_sync_q     <= 1'b0;
            state_q       <= ST_WAIT_HIGH;
            byte_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
            run_status_q  <= 8'h00;
            data_cnt_q    <= 1'b0;
            event_q       <= 24'h000000;
            event_valid_q <= 1'b0;
        end else begin
            rx_meta_q     <= rx_meta_d;
            rx_sync_q     <= rx_sync_d;
            state_q       <= state_d;
            byte_valid_q  <= byte_valid_d;
            framing_err_q <= framing_err_d;
            run_status_q  <= run_status_d;
            data_cnt_q    <= data_cnt_d;
            event_q       <= event_d;
            event_valid_q <= event_valid_d;
        end
    end

    assign midi_event_out  = event_q;
    assign event_valid_out = event_valid_q;
    assign framing_err_out = framing_err_q;

endmodule

// File: tb/tb_midi_rx.sv
// Directed bench for midi_rx: serialises MIDI bytes at a short bit period and checks events/errors.
module tb_midi_rx;

    localparam int BAUD   = 16;
    localparam int EV_LAT = BAUD / 2 + 9 * BAUD + 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [23:0] ev;
    logic        ev_v;
    logic        ferr;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ev_cnt = 0;
    int err_cnt = 0;
    int wide_cnt = 0;
    int last_ev_cyc = 0;
    int last_start = 0;
    logic prev_v = 1'b0;

    midi_rx #(.BAUD_DIV(BAUD)) dut (
        .clk_in(clk),
        .rst_in(rst_n),
        .rx_in(rx),
        .midi_event_out(ev),
        .event_valid_out(ev_v),
        .framing_err_out(ferr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (ev_v) begin
            ev_cnt++;
            last_ev_cyc = cyc;
            if (prev_v) wide_cnt++;
        end
        if (ferr) err_cnt++;
        prev_v = ev_v;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop = 1'b1);
        last_start = cyc;
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        if (good_stop) begin
            rx = 1'b1;
            repeat (BAUD) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (2 * BAUD) @(negedge clk);
            rx = 1'b1;
            repeat (BAUD) @(negedge clk);
        end
    endtask

    int ev0;
    int er0;
    logic [23:0] vel0_exp;

    initial begin
`ifdef MIDI_VEL0_NOTE_OFF_EN
        vel0_exp = 24'h803C00;
`else
        vel0_exp = 24'h903C00;
`endif
        repeat (5) @(negedge clk);
        chk("rst_event", {8'h0, ev}, 32'h0);
        chk("rst_valid", {31'h0, ev_v}, 32'h0);
        chk("rst_ferr", {31'h0, ferr}, 32'h0);
        rst_n = 1'b1;
        repeat (3 * BAUD) @(negedge clk);

        // Basic note-on, with exact latency from last start bit.
        ev0 = ev_cnt;
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        chk("noteon_val", {8'h0, ev}, 32'h903C64);
        chk("noteon_cnt", ev_cnt - ev0, 1);
        chk("noteon_lat", last_ev_cyc - last_start, EV_LAT);

        // Running status.
        ev0 = ev_cnt;
        send_byte(8'hB0); send_byte(8'h01); send_byte(8'h40);
        chk("cc1_val", {8'h0, ev}, 32'hB00140);
        send_byte(8'h48); send_byte(8'h7F);
        chk("cc2_val", {8'h0, ev}, 32'hB0487F);
        chk("cc_cnt", ev_cnt - ev0, 2);

        // Real-time byte between data bytes.
        ev0 = ev_cnt;
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
        chk("rt_val", {8'h0, ev}, 32'h903C64);
        chk("rt_cnt", ev_cnt - ev0, 1);

        // SysEx drop.
        ev0 = ev_cnt;
        send_byte(8'hF0); send_byte(8'h11); send_byte(8'h22);
        send_byte(8'hF7); send_byte(8'h33); send_byte(8'h44);
        chk("sysex_cnt", ev_cnt - ev0, 0);
        chk("sysex_hold", {8'h0, ev}, 32'h903C64);

        // Velocity-0 note-on.
        ev0 = ev_cnt;
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h00);
        chk("vel0_val", {8'h0, ev}, {8'h0, vel0_exp});
        chk("vel0_cnt", ev_cnt - ev0, 1);

        // Program change emits nothing.
        ev0 = ev_cnt;
        send_byte(8'hC0); send_byte(8'h05); send_byte(8'h06);
        chk("pc_cnt", ev_cnt - ev0, 0);

        // Framing error, then clean recovery.
        ev0 = ev_cnt; er0 = err_cnt;
        send_byte(8'h55, 1'b0);
        chk("ferr_cnt", err_cnt - er0, 1);
        chk("ferr_noev", ev_cnt - ev0, 0);
        repeat (BAUD) @(negedge clk);
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
        chk("recov_val", {8'h0, ev}, 32'h803C00);
        chk("recov_cnt", ev_cnt - ev0, 1);

        // Short low glitch.
        ev0 = ev_cnt; er0 = err_cnt;
        rx = 1'b0;
        repeat (BAUD / 4) @(negedge clk);
        rx = 1'b1;
        repeat (12 * BAUD) @(negedge clk);
        chk("glitch_err", err_cnt - er0, 0);
        chk("glitch_ev", ev_cnt - ev0, 0);

        // Reset in the middle of a message's second byte, released with the line low.
        send_byte(8'h90);
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        rx = 1'b0;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        ev0 = ev_cnt; er0 = err_cnt;
        repeat (12 * BAUD) @(negedge clk);
        chk("mrst_event", {8'h0, ev}, 32'h0);
        chk("mrst_noev", ev_cnt - ev0, 0);
        chk("mrst_noerr", err_cnt - er0, 0);
        rx = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        send_byte(8'h10); send_byte(8'h20);
        chk("mrst_norun", ev_cnt - ev0, 0);
        send_byte(8'hE0); send_byte(8'h00); send_byte(8'h40);
        chk("pb_val", {8'h0, ev}, 32'hE00040);
        chk("pb_cnt", ev_cnt - ev0, 1);

        chk("pulse_width", wide_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
